// File: rtl/sig_capture.sv
// sig_capture: triggered capture buffer with pre-trigger history and a
// chronological valid/ready readout of the full DEPTH-sample window.
`timescale 1ns/1ps
module sig_capture #(
    parameter int unsigned ADDRESS_WIDTH = 9,
    parameter int unsigned DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     arm,
    input  logic [ADDRESS_WIDTH-1:0] pre_trig,
    input  logic [DATA_WIDTH-1:0]    threshold,
    input  logic [DATA_WIDTH-1:0]    mic_signal,
    output logic [DATA_WIDTH-1:0]    dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               state
);

    localparam int unsigned AW    = ADDRESS_WIDTH;
    localparam int unsigned CW    = ADDRESS_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        POST    = 2'd2,
        READOUT = 2'd3
    } state_t;

    state_t                st;
    logic [AW-1:0]         pre_q;
    logic [AW-1:0]         wptr;
    logic [AW-1:0]         fill;
    logic [AW-1:0]         trig_addr;
    logic [AW-1:0]         rptr;
    logic [CW-1:0]         post_cnt;
    logic [CW-1:0]         issued;
    logic [CW-1:0]         xfer_cnt;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata;

    logic [CW-1:0]         post_target_c;
    logic                  we_c;
    logic                  trig_c;
    logic                  xfer_c;
    logic                  load_c;
    logic [AW-1:0]         rd_addr_c;

    assign state = st;

    // Number of samples (trigger included) that follow the pre-trigger history.
    assign post_target_c = CW'(DEPTH) - CW'(pre_q);
    assign we_c          = !reset && en && ((st == ARMED) || (st == POST));
    assign trig_c        = en && (st == ARMED) && (mic_signal >= threshold) && (fill == pre_q);
    assign xfer_c        = dout_valid && dout_ready;
    // Move the next RAM word into the output register when the slot is free or draining.
    assign load_c        = (st == READOUT) && rd_ok && (issued != CW'(DEPTH)) &&
                           (!dout_valid || dout_ready);
    // Read address runs one word ahead so rdata always holds RAM[rptr].
    assign rd_addr_c     = load_c ? rptr + AW'(1) : rptr;

    // Sample RAM write port.
    always_ff @(posedge clk) begin
        if (we_c) begin
            mem[wptr] <= mic_signal;
        end
    end

    // Sample RAM synchronous read port.
    always_ff @(posedge clk) begin
        rdata <= mem[rd_addr_c];
    end

    // Capture/readout state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= IDLE;
            pre_q      <= '0;
            wptr       <= '0;
            fill       <= '0;
            trig_addr  <= '0;
            rptr       <= '0;
            post_cnt   <= '0;
            issued     <= '0;
            xfer_cnt   <= '0;
            rd_ok      <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (st)
                IDLE: begin
                    rd_ok <= 1'b0;
                    // done marks the cycle right after readout; arm is not taken then.
                    if (arm && !done) begin
                        st    <= ARMED;
                        busy  <= 1'b1;
                        pre_q <= pre_trig;
                        wptr  <= '0;
                        fill  <= '0;
                    end
                end

                ARMED: begin
                    if (en) begin
                        wptr <= wptr + AW'(1);
                        if (trig_c) begin
                            trig_addr <= wptr;
                            post_cnt  <= CW'(1);
                            if (post_target_c == CW'(1)) begin
                                st       <= READOUT;
                                rptr     <= wptr - pre_q;
                                issued   <= '0;
                                xfer_cnt <= '0;
                                rd_ok    <= 1'b0;
                            end else begin
                                st <= POST;
                            end
                        end else if (fill != pre_q) begin
                            fill <= fill + AW'(1);
                        end
                    end
                end

                POST: begin
                    if (en) begin
                        wptr     <= wptr + AW'(1);
                        post_cnt <= post_cnt + CW'(1);
                        if (post_cnt + CW'(1) == post_target_c) begin
                            st       <= READOUT;
                            rptr     <= trig_addr - pre_q;
                            issued   <= '0;
                            xfer_cnt <= '0;
                            rd_ok    <= 1'b0;
                        end
                    end
                end

                READOUT: begin
                    rd_ok <= 1'b1;
                    if (load_c) begin
                        dout       <= rdata;
                        dout_valid <= 1'b1;
                        rptr       <= rptr + AW'(1);
                        issued     <= issued + CW'(1);
                    end else if (xfer_c) begin
                        dout_valid <= 1'b0;
                    end
                    if (xfer_c) begin
                        xfer_cnt <= xfer_cnt + CW'(1);
                        if (xfer_cnt == CW'(DEPTH - 1)) begin
                            st         <= IDLE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            dout_valid <= 1'b0;
                            rd_ok      <= 1'b0;
                        end
                    end
                end

                default: st <= IDLE;
            endcase
        end
    end

endmodule
